// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the MM:SS stopwatch
//               controller: FSM state encoding, seconds wrap limit, BCD
//               digit width and a BCD split helper for wrap limits.
// Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    // Width of one BCD digit
    localparam int DIGIT_W = 4;

    // Highest seconds value before wrapping to 00
    localparam int SEC_MAX = 59;

    // Controller states, explicitly encoded
    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    // Tens digit of a 0..99 value
    function automatic logic [DIGIT_W-1:0] bcd_tens(input int v);
        return DIGIT_W'((v / 10) % 10);
    endfunction

    // Ones digit of a 0..99 value
    function automatic logic [DIGIT_W-1:0] bcd_ones(input int v);
        return DIGIT_W'(v % 10);
    endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_wrap_counter
// Description : Two-digit BCD counter that wraps to 00 after reaching a
//               run-time wrap limit. Clear beats increment. The carry-out
//               is combinational so the next field can advance on the same
//               clock edge as this one wraps.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_inc         - increment enable (one cycle)
//               i_clr         - synchronous clear to 00
//               i_lim_tens/ones - BCD wrap limit
//               o_tens/o_ones - registered BCD digits
//               o_carry       - high when this cycle's increment wraps
// Revision    : 1.0  initial release
// ============================================================================
module bcd_wrap_counter
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_inc,
    input  logic               i_clr,
    input  logic [DIGIT_W-1:0] i_lim_tens,
    input  logic [DIGIT_W-1:0] i_lim_ones,
    output logic [DIGIT_W-1:0] o_tens,
    output logic [DIGIT_W-1:0] o_ones,
    output logic               o_carry
);

    localparam logic [DIGIT_W-1:0] c_NINE = DIGIT_W'(9);

    logic [DIGIT_W-1:0] r_tens;
    logic [DIGIT_W-1:0] r_ones;
    logic               w_at_limit;

    assign w_at_limit = (r_tens == i_lim_tens) && (r_ones == i_lim_ones);

    // A clear in the same cycle suppresses the carry, so the next field is
    // not bumped while everything is being zeroed.
    assign o_carry = i_inc & w_at_limit & ~i_clr;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_inc) begin
            if (w_at_limit) begin
                r_tens <= '0;
                r_ones <= '0;
            end else if (r_ones >= c_NINE) begin
                r_tens <= r_tens + DIGIT_W'(1);
                r_ones <= '0;
            end else begin
                r_ones <= r_ones + DIGIT_W'(1);
            end
        end
    end

    assign o_tens = r_tens;
    assign o_ones = r_ones;

endmodule : bcd_wrap_counter
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : MM:SS stopwatch controller. Three-state FSM (PAUSED, RUN,
//               ADJUST) driving a seconds and a minutes BCD wrap counter.
//               RUN counts seconds on tick_1hz with carry into minutes;
//               ADJUST steps the selected field on tick_2hz with no carry
//               and blinks that field. Clock division is done elsewhere.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               tick_1hz, tick_2hz  - one-cycle enables from the divider
//               blink               - blink phase level
//               pause_p, clear_p    - debounced button pulses
//               adj, sel            - adjust mode / field select (1 = sec)
//               min_t, min_o, sec_t, sec_o - BCD digits of MM:SS
//               blank_min, blank_sec - field blank requests
//               running             - 1 while in RUN
// Revision    : 1.0  initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               blink,
    input  logic               pause_p,
    input  logic               clear_p,
    input  logic               adj,
    input  logic               sel,
    output logic [DIGIT_W-1:0] min_t,
    output logic [DIGIT_W-1:0] min_o,
    output logic [DIGIT_W-1:0] sec_t,
    output logic [DIGIT_W-1:0] sec_o,
    output logic               blank_min,
    output logic               blank_sec,
    output logic               running
);

    localparam logic [DIGIT_W-1:0] c_SEC_LIM_T = bcd_tens(SEC_MAX);
    localparam logic [DIGIT_W-1:0] c_SEC_LIM_O = bcd_ones(SEC_MAX);
    localparam logic [DIGIT_W-1:0] c_MIN_LIM_T = bcd_tens(MAX_MIN);
    localparam logic [DIGIT_W-1:0] c_MIN_LIM_O = bcd_ones(MAX_MIN);

    state_t r_state;
    logic   r_running;
    logic   r_blank_min;
    logic   r_blank_sec;

    logic   w_sec_inc;
    logic   w_min_inc;
    logic   w_sec_carry;
    logic   w_min_carry;

    // adj wins over pause_p, so a pause pulse coinciding with adj=1 is lost.
    function automatic state_t next_state(input state_t cur, input logic a,
                                          input logic p);
        state_t nxt;
        nxt = cur;
        if (a) begin
            nxt = ADJUST;
        end else begin
            case (cur)
                PAUSED:  nxt = p ? RUN : PAUSED;
                RUN:     nxt = p ? PAUSED : RUN;
                ADJUST:  nxt = PAUSED;
                default: nxt = PAUSED;
            endcase
        end
        return nxt;
    endfunction

    // Increments depend on the current state only, so a pause in the same
    // cycle as a tick still lets that tick count.
    assign w_sec_inc = ((r_state == RUN)    & tick_1hz) |
                       ((r_state == ADJUST) & tick_2hz &  sel);
    assign w_min_inc = ((r_state == RUN)    & w_sec_carry) |
                       ((r_state == ADJUST) & tick_2hz & ~sel);

    // Outputs are registered from the state being entered, so running and
    // the blanks line up with the state on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PAUSED;
            r_running   <= 1'b0;
            r_blank_min <= 1'b0;
            r_blank_sec <= 1'b0;
        end else begin
            r_state     <= next_state(r_state, adj, pause_p);
            r_running   <= (next_state(r_state, adj, pause_p) == RUN);
            r_blank_min <= (next_state(r_state, adj, pause_p) == ADJUST) &
                           blink & ~sel;
            r_blank_sec <= (next_state(r_state, adj, pause_p) == ADJUST) &
                           blink & sel;
        end
    end

    bcd_wrap_counter u_sec (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_sec_inc),
        .i_clr      (clear_p),
        .i_lim_tens (c_SEC_LIM_T),
        .i_lim_ones (c_SEC_LIM_O),
        .o_tens     (sec_t),
        .o_ones     (sec_o),
        .o_carry    (w_sec_carry)
    );

    bcd_wrap_counter u_min (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_min_inc),
        .i_clr      (clear_p),
        .i_lim_tens (c_MIN_LIM_T),
        .i_lim_ones (c_MIN_LIM_O),
        .o_tens     (min_t),
        .o_ones     (min_o),
        .o_carry    (w_min_carry)
    );

    // Minutes wrap silently; there is no hours field to carry into.
    logic w_unused;
    assign w_unused = w_min_carry;

    assign running   = r_running;
    assign blank_min = r_blank_min;
    assign blank_sec = r_blank_sec;

endmodule : stopwatch_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl: a table of directed
//               single-cycle vectors plus hand-written multi-cycle sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       blink = 1'b0;
    logic       pause_p = 1'b0;
    logic       clear_p = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic       blank_min, blank_sec, running;
    logic [15:0] disp;

    int checks = 0;
    int errors = 0;

    assign disp = {min_t, min_o, sec_t, sec_o};

    always #5 clk = ~clk;

    stopwatch_ctrl #(.MAX_MIN(59)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .blink     (blink),
        .pause_p   (pause_p),
        .clear_p   (clear_p),
        .adj       (adj),
        .sel       (sel),
        .min_t     (min_t),
        .min_o     (min_o),
        .sec_t     (sec_t),
        .sec_o     (sec_o),
        .blank_min (blank_min),
        .blank_sec (blank_sec),
        .running   (running)
    );

    typedef struct {
        logic        p, c, t1, t2, a, s, b;
        logic [15:0] disp;
        logic        run, bm, bs;
    } vec_t;

    vec_t vecs [18];

    // Drive one cycle of inputs at the falling edge; return 1 time unit
    // after the following rising edge, ready for sampling.
    task automatic step(input logic r, input logic p, input logic c,
                        input logic t1, input logic t2, input logic a,
                        input logic s, input logic b);
        @(negedge clk);
        rst = r; pause_p = p; clear_p = c; tick_1hz = t1; tick_2hz = t2;
        adj = a; sel = s; blink = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [15:0] e_disp,
                           input logic e_run, input logic e_bm,
                           input logic e_bs);
        chk({name, ".disp"}, disp, e_disp);
        chk({name, ".running"}, {15'd0, running}, {15'd0, e_run});
        chk({name, ".blank_min"}, {15'd0, blank_min}, {15'd0, e_bm});
        chk({name, ".blank_sec"}, {15'd0, blank_sec}, {15'd0, e_bs});
    endtask

    initial begin
        //            p     c     t1    t2    a     s     b     disp     run   bm    bs
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0103, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0103, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0103, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0103, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 1);
        chk_all("reset", 16'h0000, 0, 0, 0);

        // Ticks ignored after reset until a pause pulse
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
        chk_all("post_reset_ticks", 16'h0000, 0, 0, 0);

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            step(0, vecs[i].p, vecs[i].c, vecs[i].t1, vecs[i].t2,
                 vecs[i].a, vecs[i].s, vecs[i].b);
            chk_all($sformatf("vec%0d", i), vecs[i].disp, vecs[i].run,
                    vecs[i].bm, vecs[i].bs);
        end

        // Reset in RUN with a coincident tick, then 61 seconds -> 01:01
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        chk_all("rst_in_run", 16'h0000, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 61; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
        chk_all("sixty_one_ticks", 16'h0101, 1, 0, 0);

        // Preload 59:59 through ADJUST, then one running tick wraps to 00:00
        step(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 58; i++) step(0, 0, 0, 0, 1, 1, 0, 0);
        chk_all("adj_min_59", 16'h5901, 0, 0, 0);
        for (int i = 0; i < 58; i++) step(0, 0, 0, 0, 1, 1, 1, 0);
        chk_all("adj_5959", 16'h5959, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk_all("adj_exit", 16'h5959, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk_all("wrap_5959", 16'h0000, 1, 0, 0);

        // Seconds adjust 00:58 + 3 -> 00:01, no carry; blank follows blink
        step(0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 58; i++) step(0, 0, 0, 0, 1, 1, 1, 0);
        chk_all("adj_sec_58", 16'h0058, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 1, 1);
        chk_all("adj_sec_wrap", 16'h0001, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        chk_all("blink_low", 16'h0001, 0, 0, 0);
        // Minutes adjust wraps 59 -> 00 without touching seconds
        for (int i = 0; i < 60; i++) step(0, 0, 0, 0, 1, 1, 0, 1);
        chk_all("adj_min_wrap", 16'h0001, 0, 1, 0);

        // RUN at 00:10, pause + tick same cycle -> 00:11 and stopped
        step(0, 0, 1, 0, 0, 0, 0, 0);
        chk_all("clear_exit_adj", 16'h0000, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
        chk_all("run_0010", 16'h0010, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        chk_all("pause_tick", 16'h0011, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
        chk_all("paused_ticks", 16'h0011, 0, 0, 0);

        // Reset during ADJUST with a coincident tick_2hz
        step(0, 0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 0, 1, 1, 1, 1);
        chk_all("adj_before_rst", 16'h0013, 0, 0, 1);
        step(1, 0, 0, 0, 1, 1, 1, 1);
        chk_all("rst_in_adjust", 16'h0000, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 1);
        chk_all("after_rst_tick", 16'h0000, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_stopwatch_ctrl
`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: MAX_MIN, default 59, highest minutes value before wrap to 00 (range 1..99).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 tick_1hz  input  1  one-cycle enable pulse from the clock divider, 1 Hz.
REQ-005 tick_2hz  input  1  one-cycle enable pulse from the clock divider, 2 Hz.
REQ-006 blink  input  1  level from the clock divider, roughly 50% duty blink phase.
REQ-007 pause_p  input  1  debounced one-cycle pause/resume button pulse.
REQ-008 clear_p  input  1  debounced one-cycle clear button pulse.
REQ-009 adj  input  1  level; 1 = adjust mode.
REQ-010 sel  input  1  level; adjust field select: 0 = minutes, 1 = seconds.
REQ-011 min_t, min_o, sec_t, sec_o  output  4 each  BCD digits of MM:SS.
REQ-012 blank_min, blank_sec  output  1 each  1 = display field shall be blanked.
REQ-013 running  output  1  1 while state is RUN.

Function
REQ-014 The FSM shall have exactly three states: PAUSED, RUN, ADJUST.
REQ-015 PAUSED->RUN and RUN->PAUSED shall occur on pause_p when adj=0.
REQ-016 Any state shall go to ADJUST on the cycle after adj=1 is sampled; ADJUST shall go to PAUSED on the cycle after adj=0 is sampled.
REQ-017 pause_p shall be ignored in ADJUST and in any cycle where adj=1.
REQ-018 In RUN, each tick_1hz shall increment seconds; a seconds increment from 59 shall give 00 and carry one into minutes.
REQ-019 Minutes shall wrap from MAX_MIN to 00; 59:59 (MAX_MIN=59) plus one tick shall give 00:00.
REQ-020 In ADJUST, each tick_2hz shall increment only the field chosen by sel; it shall wrap at 59 (seconds) or MAX_MIN (minutes), with no carry.
REQ-021 tick_1hz shall be ignored outside RUN; tick_2hz shall be ignored outside ADJUST.
REQ-022 clear_p shall set all digits to 0 in any state and shall not change the state.
REQ-023 clear_p shall take priority over a tick in the same cycle; the result shall be 00:00.
REQ-024 When pause_p and tick_1hz arrive in the same RUN cycle, the increment shall be applied and the next state shall be PAUSED.
REQ-025 A change of sel in ADJUST shall take effect on the next tick_2hz; there shall be no spurious increment.
REQ-026 In ADJUST: blank_min = blink & ~sel; blank_sec = blink & sel. In all other states both shall be 0.
REQ-027 All outputs shall be registered; a digit change shall be visible on the cycle after the enabling tick or pulse is sampled.
REQ-028 Digits shall always be valid BCD: tens 0..5 for seconds; 0..9 for ones.

Reset
REQ-029 rst shall force state PAUSED, all digits 0, blank_min=0, blank_sec=0, running=0, on the next rising edge.
REQ-030 rst shall take priority over all other inputs, including in mid-ADJUST and in the same cycle as a tick.
REQ-031 After rst, the block shall ignore ticks until a pause_p moves it to RUN.

Structure
REQ-032 Package stopwatch_pkg shall hold the state enumeration (PAUSED, RUN, ADJUST), SEC_MAX=59, and the BCD digit width (4).
REQ-033 A sub-module bcd_wrap_counter shall be used: a two-digit BCD counter with inc, clr, a wrap-limit input, and a carry-out pulse; it shall be instantiated once for seconds and once for minutes.
REQ-034 The FSM and blanking logic shall reside in stopwatch_ctrl; no clock division shall be done in this block.

Verification
REQ-035 Reset, pause_p, then 61 tick_1hz -> 01:01, running=1.
REQ-036 Preload to 59:59 via ADJUST, exit, pause_p, one tick_1hz -> 00:00.
REQ-037 adj=1, sel=1, 3 tick_2hz from 00:58 -> 00:01 with minutes unchanged; blank_sec follows blink and blank_min=0.
REQ-038 In RUN, clear_p and tick_1hz in the same cycle -> 00:00, running stays 1.
REQ-039 In RUN at 00:10, pause_p and tick_1hz in the same cycle -> 00:11, running=0; further ticks leave 00:11.
REQ-040 rst asserted during ADJUST with a coincident tick_2hz -> 00:00, PAUSED, blanks 0.
